multicycle_sequencer: RTL and testbench

Multi-cycle control FSM for the 16-bit processor. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and issues per-state datapath strobes: PC write, IR write, register write and memory request. Memory is reached over a req/ready handshake. It sits between the instruction register and the shared datapath (register file, ALU, PC unit, single-port memory), and uses the same opcode/function-code map and ALUop encoding as the combinational decoder.

---
 rtl/multicycle_sequencer.sv | 139 +++++++++++++
 tb/tb_multicycle_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with per-state datapath strobes
// and a req/ready memory handshake. Outputs are combinational from state and inputs.
module multicycle_sequencer #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         instr,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_b,
  output logic [3:0]          alu_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                wb_sel,
  output logic                instr_done,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t                r_state, w_next;
  logic [RETIRE_W-1:0]   r_retired;
  logic [3:0]            w_op, w_fn;
  logic                  w_is_r, w_is_lw, w_is_sw, w_is_addi, w_is_beq, w_is_bne, w_is_jmp;
  logic                  w_illegal, w_taken;

  assign w_op      = instr[15:12];
  assign w_fn      = instr[3:0];
  assign w_is_r    = (w_op == 4'd0) && (w_fn <= 4'd3);
  assign w_is_lw   = (w_op == 4'd1);
  assign w_is_sw   = (w_op == 4'd2);
  assign w_is_addi = (w_op == 4'd3);
  assign w_is_beq  = (w_op == 4'd4);
  assign w_is_bne  = (w_op == 4'd5);
  assign w_is_jmp  = (w_op == 4'd6);
  assign w_illegal = (w_op > 4'd6) || ((w_op == 4'd0) && (w_fn > 4'd3));
  assign w_taken   = (w_is_beq && alu_zero) || (w_is_bne && !alu_zero);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst)             r_retired <= '0;
    else if (instr_done) r_retired <= r_retired + 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = (w_is_jmp || w_illegal) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (w_is_lw || w_is_sw)        w_next = S_MEM;
        else if (w_is_r || w_is_addi)  w_next = S_WB;
        else                           w_next = S_FETCH;
      end
      S_MEM:    if (mem_ready) w_next = w_is_lw ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // Everything, including state and retired, reads as zero while reset is held.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_src_b    = 1'b0;
    alu_op       = 4'b0000;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    wb_sel       = 1'b0;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    state        = rst ? 3'd0 : r_state;
    retired      = rst ? '0 : r_retired;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: begin
          if (w_is_jmp) begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
          end else if (w_illegal) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_EXEC: begin
          if (w_is_r)                   alu_op = w_fn;
          else if (w_is_beq || w_is_bne) alu_op = 4'b0001;
          alu_src_b  = w_is_lw || w_is_sw || w_is_addi;
          pc_write   = w_taken;
          pc_src     = w_taken ? 2'b01 : 2'b00;
          instr_done = w_is_beq || w_is_bne;
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = w_is_sw;
          instr_done   = w_is_sw && mem_ready;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = w_is_r;
          wb_sel     = w_is_lw;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Cycle-level scoreboard bench: the driver pushes the expected output vector for every
// cycle it drives; a negedge monitor pops and compares it against the DUT.
module tb_multicycle_sequencer;
  localparam int RW = 8;

  typedef struct packed {
    logic [2:0]  st;
    logic        req, we, asel, irw, pcw;
    logic [1:0]  psrc;
    logic        srcb;
    logic [3:0]  aop;
    logic        rw, rdst, wbs, done, ill;
    logic [15:0] ret;
  } outs_t;

  logic          clk = 1'b0;
  logic          rst, alu_zero, mem_ready;
  logic [15:0]   instr;
  logic          mem_req, mem_we, mem_addr_sel, ir_write, pc_write, alu_src_b;
  logic          reg_write, reg_dst, wb_sel, instr_done, illegal;
  logic [1:0]    pc_src;
  logic [3:0]    alu_op;
  logic [RW-1:0] retired;
  logic [2:0]    state;

  outs_t         exp_q[$];
  string         tag_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [RW-1:0] er;

  always #5 clk = ~clk;

  multicycle_sequencer #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel), .instr_done(instr_done),
    .illegal(illegal), .retired(retired), .state(state)
  );

  task automatic chk(input string tag, input outs_t obs, input outs_t expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    outs_t o, e;
    string t;
    if (exp_q.size() > 0) begin
      o = '0;
      o.st = state; o.req = mem_req; o.we = mem_we; o.asel = mem_addr_sel;
      o.irw = ir_write; o.pcw = pc_write; o.psrc = pc_src; o.srcb = alu_src_b;
      o.aop = alu_op; o.rw = reg_write; o.rdst = reg_dst; o.wbs = wb_sel;
      o.done = instr_done; o.ill = illegal; o.ret = 16'(retired);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, o, e);
    end
  end

  task automatic step(input string tag, input outs_t e, input logic rdy, input logic z);
    mem_ready = rdy;
    alu_zero  = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Expected trace for one instruction; fw/mw are memory wait cycles in FETCH/MEM.
  task automatic run_instr(input string tag, input logic [15:0] iw, input logic z,
                           input int fw, input int mw, input bit abort);
    outs_t b, e;
    logic [3:0] op, fn;
    bit is_r, is_ill, is_br;
    op = iw[15:12];
    fn = iw[3:0];
    is_r   = (op == 4'd0) && (fn < 4'd4);
    is_ill = (op > 4'd6) || ((op == 4'd0) && (fn > 4'd3));
    is_br  = (op == 4'd4) || (op == 4'd5);
    instr = iw;
    b = '0;
    b.ret = 16'(er);
    for (int i = 0; i < fw; i++) begin
      e = b; e.req = 1'b1; step({tag, "/fetchwait"}, e, 1'b0, z);
    end
    e = b; e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    step({tag, "/fetch"}, e, 1'b1, z);
    e = b; e.st = 3'd1;
    if (op == 4'd6) begin e.pcw = 1'b1; e.psrc = 2'b10; e.done = 1'b1; end
    else if (is_ill) begin e.ill = 1'b1; e.done = 1'b1; end
    step({tag, "/decode"}, e, 1'b1, z);
    if (op == 4'd6 || is_ill) begin er++; return; end
    e = b; e.st = 3'd2;
    e.aop  = is_r ? fn : (is_br ? 4'b0001 : 4'b0000);
    e.srcb = (op >= 4'd1) && (op <= 4'd3);
    if ((op == 4'd4 && z) || (op == 4'd5 && !z)) begin e.pcw = 1'b1; e.psrc = 2'b01; end
    e.done = is_br;
    step({tag, "/exec"}, e, 1'b1, z);
    if (is_br) begin er++; return; end
    if (op == 4'd1 || op == 4'd2) begin
      for (int i = 0; i < mw; i++) begin
        if (abort && i == 1) begin
          rst = 1'b1;
          step({tag, "/rst"}, '0, 1'b0, z);
          rst = 1'b0;
          er = '0;
          return;
        end
        e = b; e.st = 3'd3; e.req = 1'b1; e.asel = 1'b1; e.we = (op == 4'd2);
        step({tag, "/memwait"}, e, 1'b0, z);
      end
      e = b; e.st = 3'd3; e.req = 1'b1; e.asel = 1'b1; e.we = (op == 4'd2);
      e.done = (op == 4'd2);
      step({tag, "/mem"}, e, 1'b1, z);
      if (op == 4'd2) begin er++; return; end
    end
    e = b; e.st = 3'd4; e.rw = 1'b1; e.rdst = is_r; e.wbs = (op == 4'd1); e.done = 1'b1;
    step({tag, "/wb"}, e, 1'b1, z);
    er++;
  endtask

  initial begin
    rst = 1'b1; instr = 16'h0000; alu_zero = 1'b0; mem_ready = 1'b0;
    er = '0;
    @(posedge clk);
    #1;
    step("reset0", '0, 1'b1, 1'b0);
    step("reset1", '0, 1'b1, 1'b0);
    rst = 1'b0;
    run_instr("sub",    16'h0001, 1'b0, 0, 0, 1'b0);
    run_instr("lw",     16'h1234, 1'b0, 0, 3, 1'b0);
    run_instr("add",    16'h0000, 1'b0, 2, 0, 1'b0);
    run_instr("beq_t",  16'h4123, 1'b1, 0, 0, 1'b0);
    run_instr("beq_nt", 16'h4123, 1'b0, 0, 0, 1'b0);
    run_instr("bne_nt", 16'h5123, 1'b1, 0, 0, 1'b0);
    run_instr("bne_t",  16'h5123, 1'b0, 0, 0, 1'b0);
    run_instr("jmp",    16'h6abc, 1'b0, 1, 0, 1'b0);
    run_instr("ill_op", 16'h7000, 1'b0, 0, 0, 1'b0);
    run_instr("ill_fn", 16'h0005, 1'b0, 0, 0, 1'b0);
    run_instr("ill_f",  16'hF00F, 1'b0, 0, 0, 1'b0);
    run_instr("addi",   16'h3007, 1'b0, 0, 0, 1'b0);
    run_instr("sll",    16'h0002, 1'b0, 0, 0, 1'b0);
    run_instr("and",    16'h0013, 1'b1, 0, 0, 1'b0);
    run_instr("sw",     16'h2345, 1'b0, 0, 0, 1'b0);
    run_instr("sw_w",   16'h2345, 1'b0, 0, 2, 1'b0);
    run_instr("sw_abt", 16'h2345, 1'b0, 0, 3, 1'b1);
    for (int i = 0; i < (1 << RW) - 1; i++)
      run_instr("pre", 16'h6001, 1'b0, 0, 0, 1'b0);
    run_instr("wrap",   16'h0001, 1'b0, 0, 0, 1'b0);
    run_instr("post",   16'h6002, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
